// File: rtl/i2c_target_mem.sv
// I2C target with a small register file: address match, pointer write, data
// write and data read with pointer auto-increment. SCL is never stretched.
module i2c_target_mem #(
    parameter int                    ADDR_WIDTH = 7,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] SLAVE_ADDR = 7'h22,
    parameter int                    MEM_DEPTH  = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         scl_i,
    input  logic                         sda_i,
    output logic                         sda_o,
    output logic                         scl_o,
    output logic                         busy_o,
    output logic                         wr_valid_o,
    output logic [$clog2(MEM_DEPTH)-1:0] wr_ptr_o,
    output logic [DATA_WIDTH-1:0]        wr_data_o,
    output logic [3:0]                   dbg_state_o
);
    localparam int PTR_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8,
        WAIT_STOP = 4'd9
    } state_t;

    logic                  scl_s1_q, scl_s2_q, scl_p_q;
    logic                  sda_s1_q, sda_s2_q, sda_p_q;
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic                  ack_seen_q, ack_seen_d;
    logic                  mack_q, mack_d;
    logic                  sda_q, sda_d;
    logic                  busy_q, busy_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

    logic                  scl_rise, scl_fall, start_det, stop_det, last_bit;
    logic [DATA_WIDTH-1:0] shift_in, rd_byte;

    assign scl_rise  = scl_s2_q & ~scl_p_q;
    assign scl_fall  = ~scl_s2_q & scl_p_q;
    // Conditions need SCL high on both samples so an SCL edge is never misread.
    assign start_det = scl_s2_q & scl_p_q & ~sda_s2_q & sda_p_q;
    assign stop_det  = scl_s2_q & scl_p_q & sda_s2_q & ~sda_p_q;
    assign last_bit  = (bit_cnt_q == LAST_BIT);
    assign shift_in  = {sh_q[DATA_WIDTH-2:0], sda_s2_q};
    assign rd_byte   = mem_q[ptr_q];

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        bit_cnt_d  = bit_cnt_q;
        ptr_d      = ptr_q;
        ack_seen_d = ack_seen_q;
        mack_d     = mack_q;
        sda_d      = sda_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        wr_data_d  = wr_data_q;
        mem_d      = mem_q;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_d     = 1'b1;
            busy_d    = 1'b1;
        end else if (stop_det) begin
            state_d = IDLE;
            sda_d   = 1'b1;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    sh_d      = shift_in;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        if (shift_in[ADDR_WIDTH:1] == SLAVE_ADDR) begin
                            state_d    = ADDR_ACK;
                            ack_seen_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_rise) ack_seen_d = 1'b1;
                    if (scl_fall && !ack_seen_q) begin
                        sda_d = 1'b0;
                    end else if (scl_fall) begin
                        bit_cnt_d = '0;
                        // sh_q still holds the address byte; bit 0 is R/W.
                        if (sh_q[0]) begin
                            state_d = RDATA;
                            sda_d   = rd_byte[DATA_WIDTH-1];
                            sh_d    = {rd_byte[DATA_WIDTH-2:0], 1'b0};
                        end else begin
                            state_d = PTR;
                            sda_d   = 1'b1;
                        end
                    end
                end
                PTR: if (scl_rise) begin
                    sh_d      = shift_in;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        ptr_d      = shift_in[PTR_W-1:0];
                        state_d    = PTR_ACK;
                        ack_seen_d = 1'b0;
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_rise) ack_seen_d = 1'b1;
                    if (scl_fall && !ack_seen_q) begin
                        sda_d = 1'b0;
                        if (state_q == WDATA_ACK) begin
                            mem_d[ptr_q] = sh_q;
                            wr_valid_d   = 1'b1;
                            wr_ptr_d     = ptr_q;
                            wr_data_d    = sh_q;
                            ptr_d        = ptr_q + PTR_W'(1);
                        end
                    end else if (scl_fall) begin
                        state_d   = WDATA;
                        sda_d     = 1'b1;
                        bit_cnt_d = '0;
                    end
                end
                WDATA: if (scl_rise) begin
                    sh_d      = shift_in;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        state_d    = WDATA_ACK;
                        ack_seen_d = 1'b0;
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        sda_d = sh_q[DATA_WIDTH-1];
                        sh_d  = {sh_q[DATA_WIDTH-2:0], 1'b0};
                    end
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (last_bit) begin
                            state_d    = RDATA_ACK;
                            ack_seen_d = 1'b0;
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        ack_seen_d = 1'b1;
                        mack_d     = sda_s2_q;
                        ptr_d      = ptr_q + PTR_W'(1);
                    end
                    if (scl_fall && !ack_seen_q) begin
                        sda_d = 1'b1;
                    end else if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (!mack_q) begin
                            state_d = RDATA;
                            sda_d   = rd_byte[DATA_WIDTH-1];
                            sh_d    = {rd_byte[DATA_WIDTH-2:0], 1'b0};
                        end else begin
                            state_d = WAIT_STOP;
                            sda_d   = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_p_q    <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_p_q    <= 1'b1;
            state_q    <= IDLE;
            sh_q       <= '0;
            bit_cnt_q  <= '0;
            ptr_q      <= '0;
            ack_seen_q <= 1'b0;
            mack_q     <= 1'b1;
            sda_q      <= 1'b1;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            wr_data_q  <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            scl_s1_q   <= scl_i;
            scl_s2_q   <= scl_s1_q;
            scl_p_q    <= scl_s2_q;
            sda_s1_q   <= sda_i;
            sda_s2_q   <= sda_s1_q;
            sda_p_q    <= sda_s2_q;
            state_q    <= state_d;
            sh_q       <= sh_d;
            bit_cnt_q  <= bit_cnt_d;
            ptr_q      <= ptr_d;
            ack_seen_q <= ack_seen_d;
            mack_q     <= mack_d;
            sda_q      <= sda_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_data_q  <= wr_data_d;
            mem_q      <= mem_d;
        end
    end

    assign sda_o       = sda_q;
    assign scl_o       = 1'b1;
    assign busy_o      = busy_q;
    assign wr_valid_o  = wr_valid_q;
    assign wr_ptr_o    = wr_ptr_q;
    assign wr_data_o   = wr_data_q;
    assign dbg_state_o = state_q;
endmodule

// File: doc/i2c_target_mem.md
# i2c_target_mem

Synthesizable I2C target (responder) with a small internal register file, the other end of the I2C bus driven by the `iicmb_m_wb` multi-bus controller. It decodes START/STOP, matches a fixed 7-bit address, ACKs, and services register-pointer writes, data writes and data reads with pointer auto-increment. It replaces the behavioural I2C slave BFM when a synthesizable target is needed on the bench or in an FPGA loopback.

## Interface

Parameters:
- `ADDR_WIDTH`, 7: I2C target address width.
- `DATA_WIDTH`, 8: byte width.
- `SLAVE_ADDR`, 7'h22: address this target responds to.
- `MEM_DEPTH`, 16: register-file entries; power of two; pointer width is log2(MEM_DEPTH).

Ports:
- `clk_i` in 1: system clock; must run ≥ 16× the SCL frequency.
- `rst_i` in 1: reset, asynchronous, active-low.
- `scl_i` in 1: bus SCL, read only.
- `sda_i` in 1: bus SDA.
- `sda_o` out 1: open-drain SDA drive; 0 pulls low, 1 releases.
- `scl_o` out 1: constant 1; no clock stretching.
- `busy_o` out 1: high from a START until STOP, or until return to IDLE on address mismatch.
- `wr_valid_o` out 1: one-cycle pulse when a data byte is committed to memory.
- `wr_ptr_o` out log2(MEM_DEPTH): pointer of the committed byte, valid with `wr_valid_o`.
- `wr_data_o` out DATA_WIDTH: committed byte, valid with `wr_valid_o`.

## Operation

- SCL and SDA each pass through a 2-flop synchronizer, then a registered previous-value copy for edge detection.
- START: synchronized SDA falls while SCL is high. STOP: synchronized SDA rises while SCL is high.
- Bits are sampled on SCL rising edges. `sda_o` changes only after SCL falling edges.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- IDLE → ADDR on START.
- ADDR: shift in 8 bits, MSB first (7-bit address + R/W). On match → ADDR_ACK and drive 0 for the ACK bit. On mismatch → IDLE, SDA released.
- After ADDR_ACK:
  - W → PTR.
  - R → RDATA; load `mem[ptr]` and drive its MSB after the ACK clock's falling edge.
- PTR: the 8 received bits, taken modulo MEM_DEPTH, load `ptr`. Then PTR_ACK (ACK driven) → WDATA.
- WDATA: after 8 bits, write `mem[ptr]`, pulse `wr_valid_o`, ACK, then `ptr <= ptr+1`, wrapping MEM_DEPTH-1 → 0.
- RDATA: shift `mem[ptr]` out MSB first. In RDATA_ACK, release SDA and sample the master's bit, then `ptr <= ptr+1` (wrapping).
  - Master ACK (0) → RDATA with the next byte.
  - Master NACK (1) → WAIT_STOP, SDA released.
- Repeated START in any state → ADDR. `ptr` is retained, so write-pointer-then-repeated-START-read works.
- STOP in any state → IDLE, SDA released. A partially shifted byte is discarded: no memory write and no pointer change.
- General call (address 0) is not acknowledged unless SLAVE_ADDR = 0.
- Reset:
  - `sda_o` = 1, `scl_o` = 1, `busy_o` = 0, `wr_valid_o` = 0, `wr_ptr_o` = 0, `wr_data_o` = 0.
  - `ptr` = 0, all memory = 0, state = IDLE.
  - Reset asserted mid-transfer releases SDA immediately, asynchronously.

## Timing

- Edge/condition detection latency: 3 `clk_i` cycles after a bus edge.
- `sda_o` updates at most 4 `clk_i` cycles after SCL falls. It is stable from then until SCL falls again, which satisfies data hold and setup at ≥ 16× oversampling.
- `wr_valid_o` pulses for exactly 1 cycle, at the SCL falling edge that starts the ACK bit.
- START/STOP detection has priority over bit sampling in the same cycle.
- `busy_o` rises 3 cycles after the START SDA edge and falls 3 cycles after the STOP SDA edge.

## Test plan

- Write: START, 0x44 (0x22 W), 0x03, 0xA5, 0x5A, STOP.
  - Required: ACK on all four bytes.
  - `wr_valid_o` pulses with (3, A5), then (4, 5A).
  - mem[3] = A5, mem[4] = 5A.
- Combined read: START, 0x44, 0x03, repeated START, 0x45, read two bytes (ACK, then NACK), STOP.
  - Required: reads A5, then 5A.
  - SDA released after the NACK.
- Address mismatch: START, 0x46.
  - Required: ACK bit reads 1 (NACK).
  - No memory change; `busy_o` returns to 0.
- Wrap: pointer 0x0F, write 0x11, 0x22.
  - Required: mem[15] = 11, mem[0] = 22.
  - A following read from pointer 0x0F returns 11, 22.
- Abort: STOP after 5 data bits of a write byte.
  - Required: no `wr_valid_o`, memory and `ptr` unchanged, state IDLE.
- Reset during read: assert `rst_i` low while the target drives SDA = 0.
  - Required: `sda_o` = 1 within the same cycle.
  - After release, `busy_o` = 0 and mem[3] reads 00.
